// File: rtl/axi_pkg.sv
// Shared AXI-Lite response codes and channel FSM state types.
// Response selection for out-of-range accesses depends on build macro AXIL_SLVERR_EN (see top).
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite bus bundle between a master (host bridge) and the register-bank responder.
// Handshake signals only; clock and reset travel as plain ports.
interface axi_lite_reg_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);

    logic                      s_awvalid;
    logic                      s_awready;
    logic [ADDR_WIDTH-1:0]     s_awaddr;
    logic [2:0]                s_awprot;
    logic                      s_wvalid;
    logic                      s_wready;
    logic [DATA_WIDTH-1:0]     s_wdata;
    logic [DATA_WIDTH/8-1:0]   s_wstrb;
    logic                      s_bvalid;
    logic                      s_bready;
    logic [1:0]                s_bresp;
    logic                      s_arvalid;
    logic                      s_arready;
    logic [ADDR_WIDTH-1:0]     s_araddr;
    logic                      s_rvalid;
    logic                      s_rready;
    logic [DATA_WIDTH-1:0]     s_rdata;
    logic [1:0]                s_rresp;

    modport master (
        output s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
    );

    modport slave (
        input  s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp
    );

endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite responder exposing REG_NUM byte-strobed registers plus per-register write pulses.
// Build macro AXIL_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_reg_slave
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_NUM    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    axi_lite_reg_slave_if.slave           s_axi,
    output logic [REG_NUM*DATA_WIDTH-1:0] reg_out,
    output logic [REG_NUM-1:0]            reg_wr_pulse
);

    localparam int                    STRB_W   = DATA_WIDTH / 8;
    localparam int                    ADDR_LSB = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS = ADDR_WIDTH'(REG_NUM);

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = AXI_RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = AXI_RESP_OKAY;
`endif

    wr_state_t r_wr_state, w_wr_next;
    rd_state_t r_rd_state, w_rd_next;

    logic                  r_aw_held;
    logic                  r_w_held;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [1:0]            r_bresp;
    logic [REG_NUM-1:0]    r_wr_pulse;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [ADDR_WIDTH-1:0] w_wr_addr, w_wr_idx, w_rd_idx;
    logic [DATA_WIDTH-1:0] w_wr_data, w_rd_mux;
    logic [STRB_W-1:0]     w_wr_strb;
    logic                  w_commit, w_wr_in_range, w_rd_in_range;
    logic [REG_NUM-1:0]    w_wr_sel;
    logic                  w_unused;

    assign w_unused = ^s_axi.s_awprot;

    // Readies are gated by rst so the bus sees a quiet slave for the whole reset window.
    assign w_awready = (r_wr_state == WR_IDLE) && !r_aw_held && !rst;
    assign w_wready  = (r_wr_state == WR_IDLE) && !r_w_held && !rst;
    assign w_arready = (r_rd_state == RD_IDLE) && !rst;

    assign w_aw_hs = s_axi.s_awvalid && w_awready;
    assign w_w_hs  = s_axi.s_wvalid && w_wready;
    assign w_b_hs  = w_bvalid && s_axi.s_bready;
    assign w_ar_hs = s_axi.s_arvalid && w_arready;
    assign w_r_hs  = w_rvalid && s_axi.s_rready;

    // Held values take priority; otherwise bypass the handshake happening this cycle.
    assign w_wr_addr = r_aw_held ? r_awaddr : s_axi.s_awaddr;
    assign w_wr_data = r_w_held ? r_wdata : s_axi.s_wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s_axi.s_wstrb;
    assign w_commit  = (r_wr_state == WR_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_wr_idx      = w_wr_addr >> ADDR_LSB;
    assign w_wr_in_range = w_wr_idx < NUM_REGS;
    assign w_rd_idx      = s_axi.s_araddr >> ADDR_LSB;
    assign w_rd_in_range = w_rd_idx < NUM_REGS;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
        end
    end

    always_comb begin
        w_wr_next = r_wr_state;
        w_bvalid  = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_commit) w_wr_next = WR_RESP;
            end
            WR_RESP: begin
                w_bvalid = 1'b1;
                if (s_axi.s_bready) w_wr_next = WR_IDLE;
            end
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        w_rd_next = r_rd_state;
        w_rvalid  = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_ar_hs) w_rd_next = RD_DATA;
            end
            RD_DATA: begin
                w_rvalid = 1'b1;
                if (s_axi.s_rready) w_rd_next = RD_IDLE;
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= AXI_RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_wr_sel;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_axi.s_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi.s_wdata;
                r_wstrb  <= s_axi.s_wstrb;
            end
            if (w_commit) r_bresp <= w_wr_in_range ? AXI_RESP_OKAY : OOR_RESP;
            if (w_b_hs) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // Out-of-range indices match no select line, so they neither write nor pulse.
    for (genvar g = 0; g < REG_NUM; g++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;

        assign w_wr_sel[g] = w_commit && (w_wr_idx == ADDR_WIDTH'(g));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else if (w_wr_sel[g]) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if (w_wr_strb[k]) r_q[k*8 +: 8] <= w_wr_data[k*8 +: 8];
                end
            end
        end

        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_q;
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (w_rd_idx == ADDR_WIDTH'(i)) w_rd_mux = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Capture samples pre-edge register contents, so a same-edge write is not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= AXI_RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_in_range ? w_rd_mux : '0;
            r_rresp <= w_rd_in_range ? AXI_RESP_OKAY : OOR_RESP;
        end
    end

    assign s_axi.s_awready = w_awready;
    assign s_axi.s_wready  = w_wready;
    assign s_axi.s_bvalid  = w_bvalid;
    assign s_axi.s_bresp   = r_bresp;
    assign s_axi.s_arready = w_arready;
    assign s_axi.s_rvalid  = w_rvalid;
    assign s_axi.s_rdata   = r_rdata;
    assign s_axi.s_rresp   = r_rresp;
    assign reg_wr_pulse    = r_wr_pulse;

endmodule
